// File: rtl/iobuf_turnaround_arb_pkg.sv
// Shared types and helpers for the IOBUF turnaround arbiter.
// Holds state encodings, owner encoding and the counter-width helper.
package iobuf_turnaround_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_DRIVE_A = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRIVE_B = 2'd2;
  localparam logic [STATE_W-1:0] ST_TURN    = 2'd3;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iobuf_turnaround_arb_if.sv
// Requester, pad and receive signals of the IOBUF turnaround arbiter.
// master = requester/pad side, slave = arbiter.
interface iobuf_turnaround_arb_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req_a;
  logic [WIDTH-1:0] dat_a;
  logic             gnt_a;
  logic             req_b;
  logic [WIDTH-1:0] dat_b;
  logic             gnt_b;
  logic             rx_en;
  logic [WIDTH-1:0] pad_o;
  logic [WIDTH-1:0] pad_i;
  logic             pad_t;
  logic [WIDTH-1:0] rx_dat;
  logic             rx_vld;
  logic             busy;
  logic             err;

  modport master (
    output req_a, dat_a, req_b, dat_b, rx_en, pad_o,
    input  gnt_a, gnt_b, pad_i, pad_t, rx_dat, rx_vld, busy, err
  );

  modport slave (
    input  req_a, dat_a, req_b, dat_b, rx_en, pad_o,
    output gnt_a, gnt_b, pad_i, pad_t, rx_dat, rx_vld, busy, err
  );

endinterface

// File: rtl/iobuf_turnaround_arb_rr_arb2.sv
// Two-request round-robin pick: a lone requester wins, a tie goes to
// whichever side did not own the bus last. Purely combinational.
module rr_arb2
  import iobuf_turnaround_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] win_c,
  output logic       any_c
);

  assign win_c[0] = req[0] & (~req[1] | (last_owner == OWN_B));
  assign win_c[1] = req[1] & (~req[0] | (last_owner == OWN_A));
  assign any_c    = |req;

endmodule

// File: rtl/iobuf_turnaround_arb.sv
// Shares one bidirectional IOBUF pad bus between requesters A and B with
// round-robin, capped bursts and TURN_CYC high-Z cycles between owners.
// Build option: IOBUF_TURNAROUND_ARB_LOOPBACK_CHK_EN adds a sticky pad loopback check on err.
module iobuf_turnaround_arb
  import iobuf_turnaround_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TURN_CYC  = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  iobuf_turnaround_arb_if.slave  bus
);

  localparam int unsigned BURST_W = cnt_w(MAX_BURST);
  localparam int unsigned TURN_W  = cnt_w(TURN_CYC);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURN_CYC - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [STATE_W-1:0] pick_state;
  owner_e             last_owner;
  owner_e             last_owner_nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_cnt_nxt;
  logic [TURN_W-1:0]  turn_cnt;
  logic [TURN_W-1:0]  turn_cnt_nxt;

  logic               gnt_a_nxt;
  logic               gnt_b_nxt;
  logic               busy_nxt;
  logic               pad_t_nxt;
  logic [WIDTH-1:0]   pad_i_nxt;
  logic               rx_vld_nxt;
  logic [WIDTH-1:0]   rx_dat_nxt;

  logic               beat_a;
  logic               beat_b;
  logic [1:0]         win;
  logic               any;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req_b, bus.req_a}),
    .last_owner (last_owner),
    .win_c      (win),
    .any_c      (any)
  );

  assign beat_a     = bus.gnt_a & bus.req_a;
  assign beat_b     = bus.gnt_b & bus.req_b;
  assign pick_state = win[0] ? ST_DRIVE_A : (win[1] ? ST_DRIVE_B : ST_IDLE);

  // Next state, counters and registered-output next values.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    turn_cnt_nxt   = turn_cnt;
    pad_t_nxt      = 1'b1;
    pad_i_nxt      = bus.pad_i;
    rx_vld_nxt     = bus.rx_en & bus.pad_t;
    rx_dat_nxt     = bus.rx_dat;

    case (state)
      ST_IDLE: begin
        if (any) state_nxt = pick_state;
      end
      ST_DRIVE_A: begin
        if (!bus.req_a || (burst_cnt == BURST_LAST)) begin
          state_nxt      = ST_TURN;
          last_owner_nxt = OWN_A;
          turn_cnt_nxt   = TURN_LAST;
          burst_cnt_nxt  = '0;
        end else begin
          burst_cnt_nxt  = burst_cnt + BURST_W'(1);
        end
      end
      ST_DRIVE_B: begin
        if (!bus.req_b || (burst_cnt == BURST_LAST)) begin
          state_nxt      = ST_TURN;
          last_owner_nxt = OWN_B;
          turn_cnt_nxt   = TURN_LAST;
          burst_cnt_nxt  = '0;
        end else begin
          burst_cnt_nxt  = burst_cnt + BURST_W'(1);
        end
      end
      ST_TURN: begin
        // Bus stays high-Z until the turnaround count has fully expired.
        if (turn_cnt == '0) begin
          state_nxt = any ? pick_state : ST_IDLE;
        end else begin
          turn_cnt_nxt = turn_cnt - TURN_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (beat_a) begin
      pad_t_nxt = 1'b0;
      pad_i_nxt = bus.dat_a;
    end else if (beat_b) begin
      pad_t_nxt = 1'b0;
      pad_i_nxt = bus.dat_b;
    end

    if (rx_vld_nxt) rx_dat_nxt = bus.pad_o;
  end

  assign gnt_a_nxt = (state_nxt == ST_DRIVE_A);
  assign gnt_b_nxt = (state_nxt == ST_DRIVE_B);
  assign busy_nxt  = (state_nxt != ST_IDLE);

  // Async reset releases the pad immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_owner <= OWN_B;
      burst_cnt  <= '0;
      turn_cnt   <= '0;
      bus.gnt_a  <= 1'b0;
      bus.gnt_b  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.pad_t  <= 1'b1;
      bus.pad_i  <= '0;
      bus.rx_vld <= 1'b0;
      bus.rx_dat <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      turn_cnt   <= turn_cnt_nxt;
      bus.gnt_a  <= gnt_a_nxt;
      bus.gnt_b  <= gnt_b_nxt;
      bus.busy   <= busy_nxt;
      bus.pad_t  <= pad_t_nxt;
      bus.pad_i  <= pad_i_nxt;
      bus.rx_vld <= rx_vld_nxt;
      bus.rx_dat <= rx_dat_nxt;
    end
  end

`ifdef IOBUF_TURNAROUND_ARB_LOOPBACK_CHK_EN
  // Sticky flag: a driven pad that does not read back what we drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else if (!bus.pad_t && (bus.pad_o != bus.pad_i)) begin
      bus.err <= 1'b1;
    end
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_iobuf_turnaround_arb.sv
// Directed bench for iobuf_turnaround_arb: burst, receive, mid-drive reset,
// turnaround with burst cap, and the loopback error flag when built in.
module tb_iobuf_turnaround_arb;

  localparam int unsigned WIDTH = 8;

`ifdef IOBUF_TURNAROUND_ARB_LOOPBACK_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             lb;
  logic [WIDTH-1:0] pad_o_drv;
  int               n_tests;
  int               n_fail;

  iobuf_turnaround_arb_if #(.WIDTH(WIDTH)) bus ();

  iobuf_turnaround_arb #(
    .WIDTH     (WIDTH),
    .TURN_CYC  (2),
    .MAX_BURST (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Pad model: loop the driven value back, or present an external value.
  assign bus.pad_o = lb ? bus.pad_i : pad_o_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] burst_dat [4];
  logic       exp_t;
  logic       prev_t;
  logic [7:0] exp_i;
  logic       overlap;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    lb        = 1'b0;
    pad_o_drv = '0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.dat_a = '0;
    bus.dat_b = '0;
    bus.rx_en = 1'b0;
    burst_dat[0] = 8'h11;
    burst_dat[1] = 8'h22;
    burst_dat[2] = 8'h33;
    burst_dat[3] = 8'h44;

    // Reset values
    tick();
    tick();
    check("rst_pad_t",  32'(bus.pad_t),  32'd1);
    check("rst_pad_i",  32'(bus.pad_i),  32'd0);
    check("rst_gnt_a",  32'(bus.gnt_a),  32'd0);
    check("rst_gnt_b",  32'(bus.gnt_b),  32'd0);
    check("rst_rx_vld", 32'(bus.rx_vld), 32'd0);
    check("rst_rx_dat", 32'(bus.rx_dat), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    rst_n = 1'b1;
    lb    = 1'b1;

    // Single burst of four beats from A
    bus.req_a = 1'b1;
    bus.dat_a = burst_dat[0];
    tick();
    check("sb_gnt_a", 32'(bus.gnt_a), 32'd1);
    check("sb_busy",  32'(bus.busy),  32'd1);
    check("sb_pad_t_first", 32'(bus.pad_t), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.dat_a = burst_dat[i];
      tick();
      check($sformatf("sb_pad_i%0d", i), 32'(bus.pad_i), 32'(burst_dat[i]));
      check($sformatf("sb_pad_t%0d", i), 32'(bus.pad_t), 32'd0);
    end
    bus.req_a = 1'b0;
    tick();
    check("sb_pad_t_end", 32'(bus.pad_t), 32'd1);
    check("sb_pad_i_hold", 32'(bus.pad_i), 32'h44);
    check("sb_gnt_a_end", 32'(bus.gnt_a), 32'd0);
    check("sb_turn_busy", 32'(bus.busy), 32'd1);
    tick();
    check("sb_turn_busy2", 32'(bus.busy), 32'd1);
    tick();
    check("sb_idle_busy", 32'(bus.busy), 32'd0);

    // Receive while idle, then hold
    lb        = 1'b0;
    pad_o_drv = 8'h5A;
    bus.rx_en = 1'b1;
    tick();
    check("rx_vld", 32'(bus.rx_vld), 32'd1);
    check("rx_dat", 32'(bus.rx_dat), 32'h5A);
    bus.rx_en = 1'b0;
    pad_o_drv = 8'h00;
    tick();
    check("rx_vld_drop", 32'(bus.rx_vld), 32'd0);
    check("rx_dat_hold", 32'(bus.rx_dat), 32'h5A);

    // Reset asserted mid-drive
    lb        = 1'b1;
    bus.req_a = 1'b1;
    bus.dat_a = 8'h77;
    tick();
    tick();
    check("md_pad_t_drive", 32'(bus.pad_t), 32'd0);
    check("md_pad_i_drive", 32'(bus.pad_i), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("md_pad_t_async", 32'(bus.pad_t), 32'd1);
    check("md_gnt_a_async", 32'(bus.gnt_a), 32'd0);
    check("md_busy_async",  32'(bus.busy),  32'd0);
    check("md_pad_i_async", 32'(bus.pad_i), 32'd0);
    @(negedge clk);

    // Release with both requesting: A first, 16-beat cap, 2-cycle turn, then B
    rst_n     = 1'b1;
    bus.req_b = 1'b1;
    bus.rx_en = 1'b1;
    prev_t    = 1'b1;
    overlap   = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      bus.dat_a = 8'(e);
      bus.dat_b = 8'(8'hB0 + e);
      tick();
      exp_t = !(((e >= 2) && (e <= 17)) || (e >= 20));
      if (e == 1)       exp_i = 8'h00;
      else if (e <= 17) exp_i = 8'(e);
      else if (e <= 19) exp_i = 8'd17;
      else              exp_i = 8'(8'hB0 + e);
      check($sformatf("ta_pad_t@%0d", e), 32'(bus.pad_t), 32'(exp_t));
      check($sformatf("ta_pad_i@%0d", e), 32'(bus.pad_i), 32'(exp_i));
      check($sformatf("ta_gnt_a@%0d", e), 32'(bus.gnt_a), 32'(e <= 16));
      check($sformatf("ta_gnt_b@%0d", e), 32'(bus.gnt_b), 32'(e >= 19));
      check($sformatf("ta_rx_vld@%0d", e), 32'(bus.rx_vld), 32'(prev_t));
      if (bus.gnt_a && bus.gnt_b) overlap = 1'b1;
      prev_t = exp_t;
    end
    check("ta_no_overlap", 32'(overlap), 32'd0);

    // Pad readback disagrees with the driven value
    bus.rx_en = 1'b0;
    lb        = 1'b0;
    pad_o_drv = 8'h00;
    bus.dat_b = 8'hFF;
    tick();
    check("err_pad_i", 32'(bus.pad_i), 32'hFF);
    check("err_pad_t", 32'(bus.pad_t), 32'd0);
    tick();
    check("err_set", 32'(bus.err), 32'(ERR_EXP));
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("err_sticky", 32'(bus.err), 32'(ERR_EXP));
    check("err_idle_busy", 32'(bus.busy), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("err_clear", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
